// File: rtl/clk_gen_multi.sv
// rtl/clk_gen_multi.sv - multi-channel programmable divided-clock generator
//
// Purpose: derives NUM_CLKS divided waveforms from refclk, each with its own
// period, high time and phase delay. A settle interval followed by a one-cycle
// alignment step restarts every channel together; locked reports that all
// channels are running with aligned counters.
//
// Ports:
//   refclk      - sole clock, all logic on its rising edge
//   rst         - asynchronous active-low reset
//   cfg_valid   - reconfiguration request
//   cfg_ready   - request may be accepted this cycle (low in ALIGN and reset)
//   cfg_chan    - target channel; out-of-range indices are accepted and dropped
//   cfg_div     - period in refclk cycles (<2 disables the channel)
//   cfg_high    - high time in refclk cycles
//   cfg_phase   - phase delay in refclk cycles (>=div treated as 0)
//   outclk      - registered divided-clock waveforms
//   outclk_rise - one-cycle pulse in each outclk rising cycle
//   locked      - all channels running and aligned
module clk_gen_multi #(
  parameter int NUM_CLKS    = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 1024,
  parameter int DEF_DIV     = 2,
  parameter int DEF_HIGH    = 1
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2:0]          cfg_chan,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [DIV_W-1:0]    cfg_high,
  input  logic [DIV_W-1:0]    cfg_phase,
  output logic [NUM_CLKS-1:0] outclk,
  output logic [NUM_CLKS-1:0] outclk_rise,
  output logic                locked
);

  localparam int SCNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [SCNT_W-1:0]   scnt, scnt_nxt;
  logic [DIV_W-1:0]    div_r   [NUM_CLKS];
  logic [DIV_W-1:0]    high_r  [NUM_CLKS];
  logic [DIV_W-1:0]    phase_r [NUM_CLKS];
  logic [DIV_W-1:0]    cnt     [NUM_CLKS];
  logic [DIV_W-1:0]    cnt_nxt [NUM_CLKS];
  logic [NUM_CLKS-1:0] en;
  logic [NUM_CLKS-1:0] out_nxt, rise_nxt;
  logic                accept, chan_ok, reconf;

  // Gated by rst so the request is refused while reset is held.
  assign cfg_ready = rst && (state != ALIGN);
  assign accept    = cfg_valid && cfg_ready;
  assign chan_ok   = {1'b0, cfg_chan} < 4'(NUM_CLKS);
  assign reconf    = accept && chan_ok;

  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    case (state)
      SETTLE: begin
        if (reconf) begin
          scnt_nxt = '0;
        end else if (scnt == SCNT_LAST) begin
          state_nxt = ALIGN;
          scnt_nxt  = '0;
        end else begin
          scnt_nxt = scnt + 1'b1;
        end
      end
      ALIGN: state_nxt = LOCKED;
      LOCKED: begin
        if (reconf) begin
          state_nxt = SETTLE;
          scnt_nxt  = '0;
        end
      end
      default: begin
        state_nxt = SETTLE;
        scnt_nxt  = '0;
      end
    endcase
  end

  // Outputs are computed from the next counter value so the registered
  // waveform matches the counter value of the cycle it is visible in.
  always_comb begin
    en       = '0;
    out_nxt  = '0;
    rise_nxt = '0;
    for (int i = 0; i < NUM_CLKS; i++) begin
      en[i]      = div_r[i] >= DIV_W'(2);
      cnt_nxt[i] = cnt[i];
      if (!en[i]) begin
        cnt_nxt[i] = '0;
      end else if (state == ALIGN) begin
        if (phase_r[i] == '0 || phase_r[i] >= div_r[i])
          cnt_nxt[i] = '0;
        else
          cnt_nxt[i] = div_r[i] - phase_r[i];
      end else if (state == LOCKED && state_nxt == LOCKED) begin
        if (cnt[i] >= div_r[i] - 1'b1)
          cnt_nxt[i] = '0;
        else
          cnt_nxt[i] = cnt[i] + 1'b1;
      end
      if (state_nxt == LOCKED && en[i]) begin
        out_nxt[i]  = cnt_nxt[i] < high_r[i];
        rise_nxt[i] = (cnt_nxt[i] == '0) && (high_r[i] != '0);
      end
    end
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state       <= SETTLE;
      scnt        <= '0;
      locked      <= 1'b0;
      outclk      <= '0;
      outclk_rise <= '0;
      for (int i = 0; i < NUM_CLKS; i++) begin
        div_r[i]   <= DIV_W'(DEF_DIV);
        high_r[i]  <= DIV_W'(DEF_HIGH);
        phase_r[i] <= '0;
        cnt[i]     <= '0;
      end
    end else begin
      state       <= state_nxt;
      scnt        <= scnt_nxt;
      locked      <= (state_nxt == LOCKED);
      outclk      <= out_nxt;
      outclk_rise <= rise_nxt;
      for (int i = 0; i < NUM_CLKS; i++) begin
        cnt[i] <= cnt_nxt[i];
        if (reconf && cfg_chan == 3'(i)) begin
          div_r[i]   <= cfg_div;
          high_r[i]  <= cfg_high;
          phase_r[i] <= cfg_phase;
        end
      end
    end
  end

endmodule

// File: doc/clk_gen_multi.md
Name: clk_gen_multi

Overview:
- Parametrised, fully digital successor to the single-output PLL wrapper.
- Generates NUM_CLKS divided clock waveforms from refclk. Each channel has a runtime-programmable period, high time and phase offset.
- Provides a locked indication after a settle interval and per-channel rising-edge enable pulses for logic that stays on refclk.
- Sits between the board reference clock and the processor, memory and I/O timing logic.

Parameters:
NUM_CLKS, 4, number of output channels (1..8)
DIV_W, 16, width of period/high/phase fields
LOCK_CYCLES, 1024, refclk cycles spent in SETTLE before alignment (>=2)
DEF_DIV, 2, reset period for every channel
DEF_HIGH, 1, reset high time for every channel

Ports:
refclk  in  1  sole clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
cfg_valid  in  1  reconfiguration request
cfg_ready  out  1  request may be accepted this cycle
cfg_chan  in  3  target channel index
cfg_div  in  DIV_W  period in refclk cycles
cfg_high  in  DIV_W  high time in refclk cycles
cfg_phase  in  DIV_W  phase delay in refclk cycles
outclk  out  NUM_CLKS  registered divided-clock waveforms
outclk_rise  out  NUM_CLKS  one-cycle pulse on each outclk rising cycle
locked  out  1  all channels running and aligned

Behaviour:
- Reset (rst=0, asynchronous) drives the block to a known state:
  - all outputs 0; FSM in SETTLE with settle counter 0.
  - every channel's shadow registers set to div=DEF_DIV, high=DEF_HIGH, phase=0.
- FSM states:
  - SETTLE: outclk and outclk_rise held 0, locked=0. Settle counter increments each cycle; at LOCK_CYCLES-1, go to ALIGN.
  - ALIGN (exactly one cycle): each channel counter loads start = (phase==0 || phase>=div) ? 0 : div-phase. Go to LOCKED. Outputs still 0.
  - LOCKED: locked=1 from the first LOCKED cycle. Each counter increments each cycle and wraps from div-1 to 0.
- Per channel in LOCKED, with cnt the counter value in that cycle:
  - outclk[i] = (cnt < high), produced as a register with no combinational output path.
  - outclk_rise[i] = 1 iff cnt==0 and high!=0.
- Channel boundary settings:
  - div<2: channel disabled, outclk[i]=0, outclk_rise[i]=0, counter held at 0.
  - high==0: outclk[i] constant 0.
  - high>=div (div>=2): outclk[i] constant 1; outclk_rise[i] still pulses at cnt==0.
  - phase>=div: treated as 0.
- Config handshake:
  - cfg_ready=1 in SETTLE and LOCKED, 0 in ALIGN and during reset.
  - Accept occurs when cfg_valid && cfg_ready; the shadow registers of cfg_chan are written at that edge.
  - cfg_chan>=NUM_CLKS: the request is accepted and discarded, with no state change and locked undisturbed.
- Accepting a valid channel in LOCKED: the next cycle is in SETTLE with settle counter 0. Then locked=0, all outclk=0 and all outclk_rise=0, for every channel and not only the reconfigured one.
- Accepting in SETTLE restarts the settle counter at 0.
- Accept-to-locked latency is LOCK_CYCLES+2 cycles: locked first reads 1 in cycle accept+LOCK_CYCLES+2. After reset release, locked first reads 1 in cycle LOCK_CYCLES+1, counting the first active edge as cycle 0.
- Reset asserted mid-operation discards any in-flight configuration and restores the defaults.
- Width rule: counters are DIV_W bits, and div-phase is computed in DIV_W bits with no overflow, given the guard conditions above.

Test Plan:
- Reset release, LOCK_CYCLES=8, defaults: locked rises at cycle 9. Every outclk then toggles 1,0,1,0..., outclk_rise pulses every 2 cycles, and all channels are in phase.
- Program ch1 div=5 high=2 phase=0 while LOCKED: locked=0 the next cycle, all outputs 0. After relock, ch1 pattern is 1,1,0,0,0 repeating with rise every 5 cycles; ch0 keeps its div=2 pattern.
- ch2 div=4 high=2 phase=1, ch0 div=4 high=2 phase=0: after lock, ch2 lags ch0 by exactly 1 cycle. Check the outclk_rise offset is 1.
- Boundary programming:
  - ch3 div=1: held 0 with no rise pulses.
  - ch3 div=6 high=6: constant 1 with a rise pulse every 6 cycles.
  - ch3 div=6 phase=9: identical to phase=0.
- cfg_valid held during ALIGN: cfg_ready=0 and no accept that cycle. Accept occurs in the first LOCKED cycle, then locked drops. A request with cfg_chan=7 and NUM_CLKS=4 leaves locked high.
- Assert rst mid-SETTLE after programming ch1 div=5: all outputs 0 immediately (asynchronously). After release, ch1 runs at the default div=2.
